// File: rtl/fir_window_feeder_if.sv
// Sample-source and core-FIFO signals of the FIR window feeder, bundled as one port.
// master = the feeder itself, slave = the environment (source + FIR core).
interface fir_window_feeder_if #(
   parameter int DW = 16
);
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic          able2write_in;
   logic [DW-1:0] out_data;
   logic          out_write_ctrl;
   logic          burst_done;
   logic [15:0]   burst_count;
   logic          err;

   modport master (
      input  in_data, in_valid, able2write_in,
      output in_ready, out_data, out_write_ctrl, burst_done, burst_count, err
   );

   modport slave (
      output in_data, in_valid, able2write_in,
      input  in_ready, out_data, out_write_ctrl, burst_done, burst_count, err
   );
endinterface

// File: rtl/fir_window_feeder.sv
// Keeps the last TAPS samples and writes the whole window into the FIR core FIFO per new sample.
// Define ZERO_PRIME_EN to start with a zero-filled history so the first sample already triggers a burst.
module fir_window_feeder #(
   parameter int TAPS          = 64,
   parameter int DW            = 16,
   parameter int DRAIN_TIMEOUT = 256
) (
   input  logic                clk,
   input  logic                reset,
   fir_window_feeder_if.master bus
);
   localparam int IW = $clog2(TAPS);
   localparam int FW = $clog2(TAPS + 1);
   localparam int TW = $clog2(DRAIN_TIMEOUT);

`ifdef ZERO_PRIME_EN
   localparam logic [FW-1:0] FILL_RST = FW'(TAPS);
`else
   localparam logic [FW-1:0] FILL_RST = '0;
`endif

   typedef enum logic [1:0] {IDLE, ARM, BURST, DRAIN} state_t;

   state_t          state_q, state_d;
   logic [DW-1:0]   hist_q [TAPS];
   logic [DW-1:0]   hist_d [TAPS];
   logic [FW-1:0]   fill_q, fill_d;
   logic [FW-1:0]   fill_next;
   logic [IW-1:0]   idx_q, idx_d;
   logic [TW-1:0]   drain_cnt_q, drain_cnt_d;
   logic [DW-1:0]   out_data_q, out_data_d;
   logic            out_write_q, out_write_d;
   logic            burst_done_q, burst_done_d;
   logic [15:0]     burst_count_q, burst_count_d;
   logic            err_q, err_d;
   logic            accept;

   assign accept    = bus.in_valid && (state_q == IDLE);
   assign fill_next = (fill_q == FW'(TAPS)) ? fill_q : fill_q + 1'b1;

   always_comb begin
      state_d       = state_q;
      fill_d        = fill_q;
      idx_d         = idx_q;
      drain_cnt_d   = drain_cnt_q;
      out_data_d    = '0;
      out_write_d   = 1'b0;
      err_d         = err_q;
      // first DRAIN cycle is the one right after the last strobe
      burst_done_d  = (state_q == DRAIN) && out_write_q;
      burst_count_d = burst_count_q + 16'(burst_done_d);
      for (int i = 0; i < TAPS; i++) begin
         hist_d[i] = hist_q[i];
      end

      case (state_q)
         IDLE: begin
            if (accept) begin
               for (int i = 0; i < TAPS - 1; i++) begin
                  hist_d[i] = hist_q[i+1];
               end
               hist_d[TAPS-1] = bus.in_data;
               fill_d = fill_next;
               if (fill_next == FW'(TAPS)) begin
                  state_d = ARM;
               end
            end
         end
         ARM: begin
            if (bus.able2write_in) begin
               state_d = BURST;
               idx_d   = '0;
            end
         end
         BURST: begin
            out_write_d = 1'b1;
            out_data_d  = hist_q[idx_q];
            // core FIFO filled up before the window was complete
            if (!bus.able2write_in) begin
               err_d = 1'b1;
            end
            if (idx_q == IW'(TAPS - 1)) begin
               state_d     = DRAIN;
               drain_cnt_d = '0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DRAIN: begin
            // wait for the core to see a full FIFO so a stale able level cannot restart a burst
            if (!bus.able2write_in) begin
               state_d = IDLE;
            end else if (drain_cnt_q == TW'(DRAIN_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               drain_cnt_d = drain_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         fill_q        <= FILL_RST;
         idx_q         <= '0;
         drain_cnt_q   <= '0;
         out_data_q    <= '0;
         out_write_q   <= 1'b0;
         burst_done_q  <= 1'b0;
         burst_count_q <= '0;
         err_q         <= 1'b0;
         for (int i = 0; i < TAPS; i++) begin
            hist_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         fill_q        <= fill_d;
         idx_q         <= idx_d;
         drain_cnt_q   <= drain_cnt_d;
         out_data_q    <= out_data_d;
         out_write_q   <= out_write_d;
         burst_done_q  <= burst_done_d;
         burst_count_q <= burst_count_d;
         err_q         <= err_d;
         for (int i = 0; i < TAPS; i++) begin
            hist_q[i] <= hist_d[i];
         end
      end
   end

   assign bus.in_ready       = (state_q == IDLE);
   assign bus.out_data       = out_data_q;
   assign bus.out_write_ctrl = out_write_q;
   assign bus.burst_done     = burst_done_q;
   assign bus.burst_count    = burst_count_q;
   assign bus.err            = err_q;

endmodule

// File: tb/tb_fir_window_feeder.sv
// Randomized bench for fir_window_feeder: a queue holds the last TAPS accepted samples and
// every observed burst is compared word by word against it.
module tb_fir_window_feeder;
   localparam int TAPS = 64;
   localparam int DW   = 16;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   fir_window_feeder_if #(.DW(DW)) bus ();

   fir_window_feeder #(.TAPS(TAPS), .DW(DW), .DRAIN_TIMEOUT(256)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // observed strobes and burst_done pulses
   logic [DW-1:0] got_q [$];
   int            got_cyc [$];
   int            bd_cnt  = 0;
   int            bd_cyc  = 0;
   int            bd_seen = 0;

   always @(negedge clk) begin
      if (bus.out_write_ctrl === 1'b1) begin
         got_q.push_back(bus.out_data);
         got_cyc.push_back(cyc);
      end
      if (bus.burst_done === 1'b1) begin
         bd_cnt++;
         bd_cyc = cyc;
      end
   end

   // reference: the last TAPS accepted samples, oldest first
   logic [DW-1:0] win_q [$];
   int            exp_bursts = 0;
   logic          exp_err    = 1'b0;
   int            hs_cyc     = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      win_q.delete();
`ifdef ZERO_PRIME_EN
      for (int i = 0; i < TAPS; i++) win_q.push_back('0);
`endif
      exp_bursts = 0;
      exp_err    = 1'b0;
      got_q.delete();
      got_cyc.delete();
      bd_seen = bd_cnt;
   endtask

   task automatic feed(input logic [DW-1:0] d);
      int t = 0;
      @(negedge clk);
      while (bus.in_ready !== 1'b1 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      chk("ready_wait", 32'(t < 1000), 1);
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      hs_cyc       = cyc;
      bus.in_valid = 1'b0;
      win_q.push_back(d);
      if (win_q.size() > TAPS) void'(win_q.pop_front());
      $display("sample %04h accepted at cycle %0d", d, hs_cyc);
   endtask

   task automatic expect_burst(input string tag, input int ref_cyc, input int lat);
      int t = 0;
      while (bd_cnt == bd_seen && t < 5000) begin
         @(negedge clk);
         t++;
      end
      chk({tag, "_done"}, 32'(t < 5000), 1);
      bd_seen = bd_cnt;
      exp_bursts++;
      chk({tag, "_len"}, got_q.size(), TAPS);
      if (got_q.size() == TAPS) begin
         for (int k = 0; k < TAPS; k++) begin
            chk($sformatf("%s_w%0d", tag, k), 32'(got_q[k]), 32'(win_q[k]));
         end
         chk({tag, "_gap"}, got_cyc[TAPS-1] - got_cyc[0], TAPS - 1);
         chk({tag, "_lat"}, got_cyc[0] - ref_cyc, lat);
         chk({tag, "_bdpos"}, bd_cyc, got_cyc[TAPS-1] + 1);
      end
      chk({tag, "_count"}, 32'(bus.burst_count), 32'(exp_bursts[15:0]));
      chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
      $display("burst %0d (%s) observed %0d words, newest %04h", exp_bursts, tag, got_q.size(),
               win_q[win_q.size()-1]);
      got_q.delete();
      got_cyc.delete();
   endtask

   task automatic expect_none(input string tag);
      repeat (5) @(negedge clk);
      chk({tag, "_strobes"}, got_q.size(), 0);
      chk({tag, "_count"}, 32'(bus.burst_count), 32'(exp_bursts[15:0]));
   endtask

   task automatic drain();
      @(negedge clk);
      bus.able2write_in = 1'b0;
      repeat (2) @(negedge clk);
      bus.able2write_in = 1'b1;
   endtask

   task automatic run_sample(input logic [DW-1:0] d);
      feed(d);
      if (win_q.size() == TAPS) begin
         expect_burst("burst", hs_cyc, 2);
         drain();
      end else begin
         expect_none("noburst");
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      model_reset();
   endtask

   initial begin
      int b;
      int bad;
      int t;
      int raise_cyc;
      bus.in_data       = '0;
      bus.in_valid      = 1'b0;
      bus.able2write_in = 1'b0;

      #3 reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_write", 32'(bus.out_write_ctrl), 0);
      chk("rst_data", 32'(bus.out_data), 0);
      chk("rst_done", 32'(bus.burst_done), 0);
      chk("rst_count", 32'(bus.burst_count), 0);
      chk("rst_err", 32'(bus.err), 0);
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      chk("rst_ready", 32'(bus.in_ready), 1);

      // basic window: samples 1..64
      bus.able2write_in = 1'b1;
      for (int i = 1; i <= TAPS; i++) run_sample(DW'(i));

      // sliding window with random samples
      for (int i = 0; i < 4; i++) run_sample(DW'($urandom));

      // pacing: stay in ARM while the core cannot accept
      @(negedge clk);
      bus.able2write_in = 1'b0;
      feed(DW'($urandom));
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (bus.in_ready !== 1'b0 || bus.out_write_ctrl !== 1'b0) bad++;
      end
      chk("pace_hold", bad, 0);
      bus.able2write_in = 1'b1;
      raise_cyc = cyc;
      expect_burst("pace", raise_cyc, 2);

      // drain timeout: able stays high after the burst
      b = bd_cyc;
      while (cyc < b + 250) @(negedge clk);
      chk("timeout_early", 32'(bus.err), 0);
      while (cyc < b + 260) @(negedge clk);
      chk("timeout_err", 32'(bus.err), 1);
      chk("timeout_ready", 32'(bus.in_ready), 1);
      repeat (20) @(negedge clk);
      chk("err_sticky", 32'(bus.err), 1);
      do_reset();
      @(negedge clk);
      chk("err_cleared", 32'(bus.err), 0);

      // reset in the middle of a burst
      bus.able2write_in = 1'b1;
      for (int i = 0; i < TAPS - 1; i++) run_sample(DW'($urandom));
      feed(DW'($urandom));
      t = 0;
      while (got_q.size() < 20 && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("midrst_reach", 32'(t < 500), 1);
      #2 reset = 1'b0;
      #1;
      chk("midrst_write", 32'(bus.out_write_ctrl), 0);
      chk("midrst_count", 32'(bus.burst_count), 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      model_reset();

      // refill, then let able2write_in fall during the burst
      for (int i = 0; i < TAPS - 1; i++) run_sample(DW'($urandom));
      feed(DW'($urandom));
      t = 0;
      while (got_q.size() < 10 && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("fall_reach", 32'(t < 500), 1);
      bus.able2write_in = 1'b0;
      exp_err = 1'b1;
      expect_burst("fall", hs_cyc, 2);
      repeat (3) @(negedge clk);
      chk("fall_ready", 32'(bus.in_ready), 1);
      chk("fall_err", 32'(bus.err), 1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
